mem_port_arbiter: RTL and testbench

// - Shares the core's single memory port between instruction fetch (IF) and load/store data (D) traffic.
// - Sits between the control/ALU datapath and the memory model.
// - Arbitrates, registers the winning request, drives it onto the port and routes the response back to its owner.
// - Data normally has priority; fetch starvation is bounded.

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store traffic.
// Optional WAIT-state timeout is enabled with `define MEM_ARB_TIMEOUT_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no transaction; grant decided combinationally this cycle
// S_ISSUE | registered request driven on mem port until accepted
// S_WAIT  | read accepted, waiting for mem_rvalid
// S_RESP  | one-cycle rvalid pulse to the owner
module mem_port_arbiter #(
  parameter int STARVE_MAX     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req_valid,
  input  logic [31:0] if_addr,
  output logic        if_req_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req_valid,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_req_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        owner,
  output logic        busy,
  output logic        err
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic          d_win;
  logic          if_win;
  logic          timeout_hit;
  logic          resp_fire;
  logic [31:0]   resp_data;

  always_comb begin
    d_win  = d_req_valid && (!if_req_valid || (starve_cnt < SW'(STARVE_MAX)));
    if_win = if_req_valid && !d_win;
  end

  // Gated with reset_n so the ready outputs drop the moment reset asserts.
  assign if_req_ready = reset_n && (state == S_IDLE) && if_win;
  assign d_req_ready  = reset_n && (state == S_IDLE) && d_win;

  always_comb begin
    resp_fire = ((state == S_ISSUE) && mem_req_ready && (mem_we || mem_rvalid)) ||
                ((state == S_WAIT) && (mem_rvalid || timeout_hit));
    resp_data = mem_rdata;
    if (mem_we)
      resp_data = '0;
    else if (timeout_hit)
      resp_data = 32'hDEADBEEF;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      starve_cnt    <= '0;
      owner         <= 1'b0;
      busy          <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wstrb     <= '0;
      if_rvalid     <= 1'b0;
      if_rdata      <= '0;
      d_rvalid      <= 1'b0;
      d_rdata       <= '0;
    end else begin
      if (!if_req_valid || if_req_ready)
        starve_cnt <= '0;
      else if (d_req_ready && (starve_cnt != SW'(STARVE_MAX)))
        starve_cnt <= starve_cnt + SW'(1);

      case (state)
        S_IDLE: begin
          if (if_req_ready || d_req_ready) begin
            state         <= S_ISSUE;
            busy          <= 1'b1;
            mem_req_valid <= 1'b1;
            owner         <= d_req_ready;
            mem_we        <= d_req_ready && d_we;
            mem_addr      <= d_req_ready ? d_addr : if_addr;
            mem_wdata     <= (d_req_ready && d_we) ? d_wdata : '0;
            mem_wstrb     <= (d_req_ready && d_we) ? d_wstrb : '0;
          end
        end
        S_ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (!resp_fire)
              state <= S_WAIT;
          end
        end
        S_WAIT: ;
        S_RESP: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          if_rvalid <= 1'b0;
          if_rdata  <= '0;
          d_rvalid  <= 1'b0;
          d_rdata   <= '0;
        end
        default: state <= S_IDLE;
      endcase

      if (resp_fire) begin
        state     <= S_RESP;
        if_rvalid <= !owner;
        d_rvalid  <= owner;
        if_rdata  <= owner ? 32'h0 : resp_data;
        d_rdata   <= owner ? resp_data : 32'h0;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt;

  assign timeout_hit = (state == S_WAIT) && !mem_rvalid &&
                       (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Held at zero outside WAIT, so it always starts from zero on entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= resp_fire && timeout_hit;
      if (state != S_WAIT)
        wait_cnt <= '0;
      else if (!timeout_hit)
        wait_cnt <= wait_cnt + TW'(1);
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; timeout steps follow MEM_ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req_valid;
  logic [31:0] if_addr;
  logic        if_req_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req_valid;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_req_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        owner;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.STARVE_MAX(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req_valid(if_req_valid), .if_addr(if_addr), .if_req_ready(if_req_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req_valid(d_req_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_req_ready(d_req_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Requester protocol: a pending request may not be withdrawn.
  logic if_pend = 1'b0;
  logic d_pend  = 1'b0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (if_pend) assert (if_req_valid) else begin
        errors++;
        $error("FAIL if_valid_drop observed 0 expected 1");
      end
      if (d_pend) assert (d_req_valid) else begin
        errors++;
        $error("FAIL d_valid_drop observed 0 expected 1");
      end
    end
    if_pend <= reset_n && if_req_valid && !if_req_ready;
    d_pend  <= reset_n && d_req_valid && !d_req_ready;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [5:0] grant_pat;

  initial begin
    reset_n = 1'b0;
    if_req_valid = 1'b1; if_addr = '0;
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // reset state
    #12;
    chk("rst_if_ready", if_req_ready, 0);
    chk("rst_d_ready", d_req_ready, 0);
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    reset_n = 1'b1;
    tick();

    // lone fetch, response one cycle after acceptance
    if_req_valid = 1'b1; if_addr = 32'h10; mem_req_ready = 1'b1;
    #1;
    chk("lf_if_ready", if_req_ready, 1);
    chk("lf_d_ready", d_req_ready, 0);
    tick();
    if_req_valid = 1'b0;
    chk("lf_mem_valid", mem_req_valid, 1);
    chk("lf_mem_addr", mem_addr, 32'h10);
    chk("lf_mem_we", mem_we, 0);
    chk("lf_mem_wstrb", mem_wstrb, 0);
    chk("lf_owner", owner, 0);
    chk("lf_busy", busy, 1);
    tick();
    chk("lf_wait_mem_valid", mem_req_valid, 0);
    chk("lf_wait_rvalid", if_rvalid, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h00940333;
    tick();
    mem_rvalid = 1'b0;
    chk("lf_if_rvalid", if_rvalid, 1);
    chk("lf_if_rdata", if_rdata, 32'h00940333);
    chk("lf_d_rvalid", d_rvalid, 0);
    chk("lf_d_rdata", d_rdata, 0);
    tick();
    chk("lf_if_rvalid_end", if_rvalid, 0);
    chk("lf_busy_end", busy, 0);

    // simultaneous: D store wins, then IF with same-cycle accept+response
    if_req_valid = 1'b1; if_addr = 32'h20;
    d_req_valid = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hAB; d_wstrb = 4'b0001;
    #1;
    chk("sim_d_ready", d_req_ready, 1);
    chk("sim_if_ready", if_req_ready, 0);
    tick();
    d_req_valid = 1'b0;
    chk("sim_mem_we", mem_we, 1);
    chk("sim_mem_wstrb", mem_wstrb, 4'b0001);
    chk("sim_mem_wdata", mem_wdata, 32'hAB);
    chk("sim_mem_addr", mem_addr, 32'h100);
    chk("sim_owner", owner, 1);
    chk("sim_if_ready_busy", if_req_ready, 0);
    tick();
    chk("sim_d_rvalid", d_rvalid, 1);
    chk("sim_d_rdata", d_rdata, 0);
    chk("sim_if_rvalid", if_rvalid, 0);
    chk("sim_resp_if_ready", if_req_ready, 0);
    tick();
    chk("sim_if_ready_next", if_req_ready, 1);
    tick();
    if_req_valid = 1'b0;
    chk("sim_if_owner", owner, 0);
    chk("sim_if_addr", mem_addr, 32'h20);
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_rvalid = 1'b0;
    chk("sim_min_lat_rvalid", if_rvalid, 1);
    chk("sim_min_lat_rdata", if_rdata, 32'h12345678);
    tick();

    // starvation: four D grants, one IF, then D again
    grant_pat = 6'b101111;
    if_req_valid = 1'b1; if_addr = 32'h30;
    d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wstrb = 4'hF;
    mem_rvalid = 1'b1; mem_rdata = 32'h55;
    for (int g = 0; g < 6; g++) begin
      #1;
      chk($sformatf("starve_d_ready_%0d", g), d_req_ready, grant_pat[g]);
      chk($sformatf("starve_if_ready_%0d", g), if_req_ready, !grant_pat[g]);
      tick();
      if (!grant_pat[g]) if_req_valid = 1'b0;
      tick();
      chk($sformatf("starve_rvalid_%0d", g), grant_pat[g] ? d_rvalid : if_rvalid, 1);
      tick();
    end
    d_req_valid = 1'b0; mem_rvalid = 1'b0;

    // backpressure on a store, IF pending meanwhile
    mem_req_ready = 1'b0;
    d_req_valid = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hCAFEF00D; d_wstrb = 4'b1100;
    #1;
    chk("bp_d_ready", d_req_ready, 1);
    tick();
    d_req_valid = 1'b0;
    if_req_valid = 1'b1; if_addr = 32'h40;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid_%0d", i), mem_req_valid, 1);
      chk($sformatf("bp_addr_%0d", i), mem_addr, 32'h300);
      chk($sformatf("bp_wdata_%0d", i), mem_wdata, 32'hCAFEF00D);
      chk($sformatf("bp_wstrb_%0d", i), mem_wstrb, 4'b1100);
      chk($sformatf("bp_if_ready_%0d", i), if_req_ready, 0);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    chk("bp_d_rvalid", d_rvalid, 1);
    tick();

    // reset in WAIT discards the read
    #1;
    chk("rw_if_ready", if_req_ready, 1);
    tick();
    if_req_valid = 1'b0;
    tick();
    chk("rw_busy_wait", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("rw_busy_rst", busy, 0);
    chk("rw_mem_addr_rst", mem_addr, 0);
    chk("rw_owner_rst", owner, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h99;
    #1;
    reset_n = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("rw_if_rvalid", if_rvalid, 0);
    chk("rw_busy_after", busy, 0);
    chk("rw_mem_valid_after", mem_req_valid, 0);
    tick();
    chk("rw_if_rvalid2", if_rvalid, 0);

    // read with no response: timeout or stays busy
    if_req_valid = 1'b1; if_addr = 32'h50;
    #1;
    chk("to_if_ready", if_req_ready, 1);
    tick();
    if_req_valid = 1'b0;
    tick();
`ifdef MEM_ARB_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("to_wait_rvalid_%0d", i), if_rvalid, 0);
      chk($sformatf("to_wait_err_%0d", i), err, 0);
    end
    tick();
    chk("to_rvalid", if_rvalid, 1);
    chk("to_err", err, 1);
    chk("to_rdata", if_rdata, 32'hDEADBEEF);
    tick();
    chk("to_err_end", err, 0);
    chk("to_busy_end", busy, 0);
`else
    for (int i = 0; i < 20; i++) tick();
    chk("nt_busy", busy, 1);
    chk("nt_rvalid", if_rvalid, 0);
    chk("nt_err", err, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    tick();
    mem_rvalid = 1'b0;
    chk("nt_late_rvalid", if_rvalid, 1);
    chk("nt_late_rdata", if_rdata, 32'h77);
    tick();
    chk("nt_busy_end", busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
